// File: rtl/irq_input_pkg.sv
// Shared constants and helpers for the board-input interrupt controller.
package irq_input_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned ADDR_W        = 3;
  localparam int unsigned DEF_DEB_W     = 20;
  localparam int unsigned DEF_DEB_RESET = 50000;

  localparam logic [ADDR_W-1:0] REG_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] REG_PENDING  = 3'd1;
  localparam logic [ADDR_W-1:0] REG_MASK     = 3'd2;
  localparam logic [ADDR_W-1:0] REG_RISE_EN  = 3'd3;
  localparam logic [ADDR_W-1:0] REG_FALL_EN  = 3'd4;
  localparam logic [ADDR_W-1:0] REG_ID       = 3'd5;
  localparam logic [ADDR_W-1:0] REG_DEBOUNCE = 3'd6;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } avl_req_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [4:0] lowest_set_idx(input logic [DATA_W-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One input line: two-flop synchroniser, debounce counter and edge pulses
// that coincide with the stable-level update.
module input_debounce
  import irq_input_pkg::*;
#(
  parameter int unsigned DEB_W = DEF_DEB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_i,
  input  logic [DEB_W-1:0] deb_len_i,
  output logic             stable_o,
  output logic             rise_pulse,
  output logic             fall_pulse
);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q, stable_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] limit;
  logic             mismatch;
  logic             fire;

  // A length of zero behaves like one, so the limit never underflows.
  assign limit    = (deb_len_i == '0) ? '0 : deb_len_i - DEB_W'(1);
  assign mismatch = sync_q ^ stable_q;
  assign fire     = mismatch && (cnt_q >= limit);

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (mismatch) begin
      if (fire) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o   = stable_q;
  assign rise_pulse = fire &  sync_q;
  assign fall_pulse = fire & ~sync_q;

endmodule

// File: rtl/irq_input_ctrl.sv
// Avalon-MM interrupt controller for debounced board inputs: edge latching
// into a W1C pending register, masking, priority ID and a level irq.
module irq_input_ctrl
  import irq_input_pkg::*;
#(
  parameter int unsigned N_IN      = 8,
  parameter int unsigned DEB_W     = DEF_DEB_W,
  parameter int unsigned DEB_RESET = DEF_DEB_RESET
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IN-1:0]     in_raw,
  input  logic [ADDR_W-1:0]   avl_address,
  input  logic                avl_read,
  input  logic                avl_write,
  input  logic [DATA_W-1:0]   avl_writedata,
  output logic [DATA_W-1:0]   avl_readdata,
  output logic                avl_irq
);

  avl_req_t          req;
  logic [N_IN-1:0]   stable;
  logic [N_IN-1:0]   rise;
  logic [N_IN-1:0]   fall;

  logic [N_IN-1:0]   pend_q, pend_d;
  logic [N_IN-1:0]   mask_q, mask_d;
  logic [N_IN-1:0]   rise_en_q, rise_en_d;
  logic [N_IN-1:0]   fall_en_q, fall_en_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;

  logic [N_IN-1:0]   active;
  logic [N_IN-1:0]   w1c;
  logic [N_IN-1:0]   edge_set;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  assign req = '{rd: avl_read, wr: avl_write, addr: avl_address, wdata: avl_writedata};
  assign unused_wdata = ^req.wdata;

  for (genvar g = 0; g < int'(N_IN); g++) begin : g_line
    input_debounce #(
      .DEB_W (DEB_W)
    ) u_deb (
      .clk        (clk),
      .reset      (reset),
      .raw_i      (in_raw[g]),
      .deb_len_i  (deb_q),
      .stable_o   (stable[g]),
      .rise_pulse (rise[g]),
      .fall_pulse (fall[g])
    );
  end

  assign active   = pend_q & mask_q;
  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c      = (req.wr && req.addr == REG_PENDING) ? req.wdata[N_IN-1:0] : '0;

  // Read mux sees pre-write register values.
  always_comb begin
    rd_mux = '0;
    case (req.addr)
      REG_STATUS:   rd_mux = DATA_W'(stable);
      REG_PENDING:  rd_mux = DATA_W'(pend_q);
      REG_MASK:     rd_mux = DATA_W'(mask_q);
      REG_RISE_EN:  rd_mux = DATA_W'(rise_en_q);
      REG_FALL_EN:  rd_mux = DATA_W'(fall_en_q);
      REG_ID:       rd_mux = {(|active), 26'd0, lowest_set_idx(DATA_W'(active))};
      REG_DEBOUNCE: rd_mux = DATA_W'(deb_q);
      default:      rd_mux = '0;
    endcase
  end

  // Edge-set takes precedence over a same-cycle W1C of the same bit.
  always_comb begin
    pend_d    = (pend_q & ~w1c) | edge_set;
    mask_d    = mask_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_d     = deb_q;
    rdata_d   = rdata_q;
    irq_d     = |active;
    if (req.wr) begin
      case (req.addr)
        REG_MASK:     mask_d    = req.wdata[N_IN-1:0];
        REG_RISE_EN:  rise_en_d = req.wdata[N_IN-1:0];
        REG_FALL_EN:  fall_en_d = req.wdata[N_IN-1:0];
        REG_DEBOUNCE: deb_d     = req.wdata[DEB_W-1:0];
        default:      ;
      endcase
    end
    if (req.rd) rdata_d = rd_mux;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q    <= '0;
      mask_q    <= '0;
      rise_en_q <= '1;
      fall_en_q <= '0;
      deb_q     <= DEB_W'(DEB_RESET);
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      deb_q     <= deb_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign avl_readdata = rdata_q;
  assign avl_irq      = irq_q;

endmodule

// File: tb/tb_irq_input_ctrl.sv
// Scoreboard bench for irq_input_ctrl: a history-based reference model pushes
// per-cycle expectations; a negedge monitor pops and compares.
module tb_irq_input_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 20;
  localparam int unsigned DR = 50000;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_raw;
  logic [2:0]    avl_address;
  logic          avl_read;
  logic          avl_write;
  logic [31:0]   avl_writedata;
  logic [31:0]   avl_readdata;
  logic          avl_irq;

  always #5 clk = ~clk;

  irq_input_ctrl #(
    .N_IN      (N),
    .DEB_W     (DW),
    .DEB_RESET (DR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_raw        (in_raw),
    .avl_address   (avl_address),
    .avl_read      (avl_read),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_readdata  (avl_readdata),
    .avl_irq       (avl_irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        irq;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A line's stable level flips once the raw samples that reached the
  // synchroniser output over the last D cycles all disagree with it.
  logic [N-1:0]  stab_m, pend_m, mask_m, rise_m, fall_m;
  logic [DW-1:0] deb_m;
  logic [31:0]   rdata_m;
  logic          irq_m;
  logic [31:0]   hist [N];

  function automatic logic [31:0] reg_val(input logic [2:0] a);
    logic [N-1:0] act;
    logic [31:0]  v;
    act = pend_m & mask_m;
    v = 32'd0;
    case (a)
      3'd0: v = {24'd0, stab_m};
      3'd1: v = {24'd0, pend_m};
      3'd2: v = {24'd0, mask_m};
      3'd3: v = {24'd0, rise_m};
      3'd4: v = {24'd0, fall_m};
      3'd5: begin
        if (act != 0) begin
          v[31] = 1'b1;
          for (int i = N - 1; i >= 0; i--) if (act[i]) v[4:0] = 5'(i);
        end
      end
      3'd6: v = {12'd0, deb_m};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  logic [N-1:0] m_rs, m_fl, m_w1c;
  logic [31:0]  m_win, m_msk;
  logic         m_irq_n;
  int           m_d;
  exp_t         m_e;

  always @(posedge clk) begin
    if (reset) begin
      stab_m = '0; pend_m = '0; mask_m = '0; rise_m = '1; fall_m = '0;
      deb_m = DW'(DR); rdata_m = 32'd0; irq_m = 1'b0;
      for (int i = 0; i < N; i++) hist[i] = 32'd0;
    end else begin
      m_d = (deb_m == 0) ? 1 : int'(deb_m);
      m_rs = '0; m_fl = '0;
      for (int i = 0; i < N; i++) begin
        if (m_d <= 30) begin
          m_msk = (32'd1 << m_d) - 32'd1;
          m_win = (hist[i] >> 1) & m_msk;
          if (!stab_m[i] && m_win == m_msk) m_rs[i] = 1'b1;
          if (stab_m[i] && m_win == 32'd0)  m_fl[i] = 1'b1;
        end
        hist[i] = {hist[i][30:0], in_raw[i]};
      end
      m_irq_n = |(pend_m & mask_m);
      if (avl_read) rdata_m = reg_val(avl_address);
      m_w1c = (avl_write && avl_address == 3'd1) ? avl_writedata[N-1:0] : '0;
      pend_m = (pend_m & ~m_w1c) | (m_rs & rise_m) | (m_fl & fall_m);
      if (avl_write) begin
        case (avl_address)
          3'd2: mask_m = avl_writedata[N-1:0];
          3'd3: rise_m = avl_writedata[N-1:0];
          3'd4: fall_m = avl_writedata[N-1:0];
          3'd6: deb_m  = avl_writedata[DW-1:0];
          default: ;
        endcase
      end
      stab_m = stab_m ^ (m_rs | m_fl);
      irq_m  = m_irq_n;
    end
    m_e.irq = irq_m;
    m_e.rdata = rdata_m;
    exp_q.push_back(m_e);
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_irq", 32'(avl_irq), 32'(mon_e.irq));
      chk("sb_readdata", avl_readdata, mon_e.rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avl_address = a; avl_writedata = d; avl_write = 1'b1;
    cyc(1);
    avl_write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
    avl_address = a; avl_read = 1'b1;
    cyc(1);
    avl_read = 1'b0;
    chk(nm, avl_readdata, exp);
  endtask

  initial begin
    reset = 1'b1; in_raw = '0;
    avl_address = 3'd0; avl_read = 1'b0; avl_write = 1'b0; avl_writedata = 32'd0;
    cyc(3);
    reset = 1'b0;
    chk("rst_irq", 32'(avl_irq), 32'd0);
    chk("rst_rdata", avl_readdata, 32'd0);
    rd_chk("rst_mask", 3'd2, 32'd0);
    rd_chk("rst_rise_en", 3'd3, 32'h0000_00FF);
    rd_chk("rst_debounce", 3'd6, 32'd50000);

    // Rising edge latency with D=4
    wr(3'd6, 32'd4);
    wr(3'd2, 32'h01);
    in_raw[0] = 1'b1;
    cyc(6);
    chk("lat_irq_e6", 32'(avl_irq), 32'd0);
    cyc(1);
    chk("lat_irq_e7", 32'(avl_irq), 32'd1);
    rd_chk("lat_id", 3'd5, 32'h8000_0000);
    rd_chk("lat_pending", 3'd1, 32'h01);
    rd_chk("lat_status", 3'd0, 32'h01);

    // Short glitch is discarded
    in_raw[2] = 1'b1; cyc(3); in_raw[2] = 1'b0; cyc(10);
    rd_chk("glitch_status", 3'd0, 32'h01);
    rd_chk("glitch_pending", 3'd1, 32'h01);
    chk("glitch_irq", 32'(avl_irq), 32'd1);

    // Falling-edge only
    wr(3'd1, 32'hFF);
    wr(3'd3, 32'h00);
    wr(3'd4, 32'h02);
    wr(3'd2, 32'h02);
    in_raw[1] = 1'b1; cyc(10);
    rd_chk("fall_no_rise", 3'd1, 32'h00);
    in_raw[1] = 1'b0; cyc(10);
    rd_chk("fall_latched", 3'd1, 32'h02);
    chk("fall_irq", 32'(avl_irq), 32'd1);

    // Priority ID and W1C
    wr(3'd3, 32'h08);
    in_raw[3] = 1'b1; cyc(10);
    wr(3'd2, 32'h0A);
    rd_chk("id_pending", 3'd1, 32'h0A);
    rd_chk("id_lowest1", 3'd5, 32'h8000_0001);
    wr(3'd1, 32'h02);
    rd_chk("id_lowest3", 3'd5, 32'h8000_0003);
    wr(3'd1, 32'h08);
    chk("w1c_irq_hold", 32'(avl_irq), 32'd1);
    rd_chk("id_none", 3'd5, 32'h0);
    chk("w1c_irq_drop", 32'(avl_irq), 32'd0);

    // Edge-set beats same-cycle W1C
    wr(3'd4, 32'h01);
    in_raw[0] = 1'b0;
    cyc(5);
    wr(3'd1, 32'h01);
    rd_chk("set_wins", 3'd1, 32'h01);
    wr(3'd1, 32'h01);
    rd_chk("w1c_clears", 3'd1, 32'h00);

    // Unmasking a pending bit raises irq one cycle later
    wr(3'd2, 32'h00);
    wr(3'd4, 32'h08);
    in_raw[3] = 1'b0; cyc(10);
    chk("masked_irq", 32'(avl_irq), 32'd0);
    rd_chk("masked_pending", 3'd1, 32'h08);
    wr(3'd2, 32'h08);
    chk("unmask_irq_e0", 32'(avl_irq), 32'd0);
    cyc(1);
    chk("unmask_irq_e1", 32'(avl_irq), 32'd1);

    // Simultaneous read and W1C of PENDING returns pre-write value
    avl_address = 3'd1; avl_writedata = 32'h08; avl_read = 1'b1; avl_write = 1'b1;
    cyc(1);
    avl_read = 1'b0; avl_write = 1'b0;
    chk("rw_prewrite", avl_readdata, 32'h08);
    rd_chk("rw_cleared", 3'd1, 32'h00);
    rd_chk("rsvd_reads0", 3'd7, 32'h00);

    // Reset mid-debounce
    wr(3'd3, 32'hFF);
    wr(3'd4, 32'h0F);
    in_raw[4] = 1'b1; cyc(3);
    reset = 1'b1; cyc(2); reset = 1'b0;
    chk("rst2_irq", 32'(avl_irq), 32'd0);
    rd_chk("rst2_pending", 3'd1, 32'h00);
    rd_chk("rst2_mask", 3'd2, 32'h00);
    rd_chk("rst2_rise_en", 3'd3, 32'hFF);
    rd_chk("rst2_fall_en", 3'd4, 32'h00);
    rd_chk("rst2_debounce", 3'd6, 32'd50000);
    rd_chk("rst2_status", 3'd0, 32'h00);

    // Randomised traffic against the model
    wr(3'd6, 32'd3);
    for (int it = 0; it < 4000; it++) begin
      if ($urandom_range(0, 5) == 0) in_raw[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        avl_address = 3'($urandom_range(0, 7));
        avl_read    = 1'($urandom_range(0, 1));
        avl_write   = 1'($urandom_range(0, 1));
        avl_writedata = (avl_address == 3'd6) ? 32'($urandom_range(0, 6)) : $urandom;
      end
      if ($urandom_range(0, 999) == 0) reset = 1'b1;
      cyc(1);
      avl_read = 1'b0; avl_write = 1'b0; reset = 1'b0;
      if (it % 700 == 699) begin
        avl_address = 3'd6; avl_writedata = 32'($urandom_range(1, 6)); avl_write = 1'b1;
        cyc(1);
        avl_write = 1'b0;
      end
    end

    cyc(3);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
